imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Byte-stream program loader that writes the processor's instruction memory.
- It is the writer side of the instruction-fetch path: it assembles incoming bytes into 32-bit words and issues word writes into instruction memory.
- It holds the processor core in reset until a complete image has been loaded and its checksum verified.
- It sits between a host byte source (UART receiver or testbench) and the instruction memory's write port, alongside the RISC top level.

Parameters:
- DEPTH, 256, instruction memory depth in 32-bit words.
- ADDR_W, 10, width of the word address driven to instruction memory.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- in_valid  input  1  byte-stream valid.
- in_data  input  8  byte-stream data.
- in_ready  output  1  loader accepts a byte this cycle; a transfer occurs when in_valid and in_ready are both high.
- imem_we  output  1  instruction memory write strobe, one cycle per word.
- imem_addr  output  ADDR_W  word address for the write.
- imem_wdata  output  32  word to write.
- cpu_rst  output  1  reset to the processor core, active high.
- busy  output  1  high in LEN_HI, LEN_LO, DATA and CHK.
- done  output  1  high in DONE.
- err  output  1  high in ERR.
- word_cnt  output  16  number of words written in the current load.

Behaviour:
- Reset (asynchronous):
  - state = IDLE; cpu_rst = 1.
  - imem_we = 0, imem_addr = 0, imem_wdata = 0.
  - word_cnt = 0, in_ready = 0; done, err and busy = 0.
- Frame format, bytes in order:
  - LEN_HI, LEN_LO: word count N, big-endian.
  - N x 4 data bytes: each word big-endian, first byte goes to [31:24].
  - CHK: one byte equal to the XOR of all preceding bytes of the frame, length bytes included.
- States:
  - IDLE: in_ready = 0; cpu_rst = 1. On start: clear the running XOR, word_cnt and byte index; go to LEN_HI.
  - LEN_HI: on transfer, latch N[15:8] and go to LEN_LO.
  - LEN_LO: on transfer, latch N[7:0].
    - If N > DEPTH, go to ERR.
    - If N = 0, go to CHK.
    - Otherwise go to DATA.
  - DATA: shift bytes into a 32-bit assembly register; a 2-bit byte index wraps 3 -> 0.
    - When the 4th byte transfers, the next cycle has: imem_we = 1 for exactly one cycle, imem_wdata = the assembled word, imem_addr = word_cnt[ADDR_W-1:0]. word_cnt increments on that same edge.
    - in_ready stays high throughout, so back-to-back words give back-to-back write strobes.
    - After word N's 4th byte, go to CHK.
  - CHK: on transfer, compare the received byte with the running XOR. Match goes to DONE; mismatch goes to ERR.
  - DONE: cpu_rst = 0; done = 1; in_ready = 0.
  - ERR: cpu_rst = 1; err = 1; in_ready = 0.
  - From DONE or ERR, start re-enters LEN_HI and clears state as in IDLE.
- in_ready = 1 only in LEN_HI, LEN_LO, DATA and CHK.
- cpu_rst is registered:
  - It falls on the edge that enters DONE.
  - It rises on the edge that leaves DONE, including a new start.
- start while busy is ignored.
- in_valid outside busy states is ignored and no byte is consumed.
- in_valid held low mid-frame: wait indefinitely; no timeout.
- Stale memory contents beyond word N are untouched.
- rst mid-load: abort immediately to IDLE with cpu_rst = 1. A partially written image is not erased.

Decomposition:
- Shared package holds:
  - the state encoding: IDLE, LEN_HI, LEN_LO, DATA, CHK, DONE, ERR;
  - the constant for the frame header length.
- One natural sub-module, word_assembler: byte shift register, 2-bit byte index and word-complete pulse. The main FSM, the XOR accumulator and the address counter stay in imem_loader.

Test Plan:
- Reset then idle bytes: pulse rst; drive in_valid = 1 with no start -> in_ready = 0, no imem_we, cpu_rst = 1.
- Basic load:
  - Stimulus: start; bytes 00 02 | DE AD BE EF | 01 23 45 67 | checksum (XOR of all ten bytes).
  - Required: writes addr 0 = DEADBEEF and addr 1 = 01234567, one cycle each; word_cnt = 2; done = 1; cpu_rst falls the cycle DONE is entered.
- Bad checksum: same frame with the checksum byte XOR 0x01 -> err = 1, cpu_rst stays 1, both writes still occurred.
- Length limits:
  - N = 0x0101 with DEPTH = 256 -> ERR after LEN_LO, no imem_we.
  - N = 0 followed by checksum 00 -> DONE with no writes.
- Throttled stream: random in_valid gaps during a 4-word load -> identical write sequence; imem_we never asserted twice for one word.
- Reset and restart:
  - rst asserted after 6 data bytes -> IDLE immediately; cpu_rst = 1; in_ready = 0.
  - A subsequent start with a full frame loads correctly.
  - start pulsed in DONE -> cpu_rst returns to 1 the next cycle.

Source files
------------

// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module  : imem_loader_pkg
// Brief   : Shared state encoding and frame constants for the program loader.
// Revision: 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_CHK    = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } state_t;

    // Length field bytes that precede the payload in every frame.
    localparam int HDR_BYTES = 2;

endpackage
`default_nettype wire

// File: rtl/imem_loader_word_assembler.sv
`default_nettype none
// ============================================================================
// Module  : imem_loader_word_assembler
// Brief   : Big-endian byte-to-word assembler with a one-cycle word-complete flag.
// Revision: 1.0 - initial release
// ============================================================================
module imem_loader_word_assembler (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_done
);

    logic [23:0] shift_q, shift_d;
    logic [1:0]  idx_q,   idx_d;

    always_comb begin
        shift_d = shift_q;
        idx_d   = idx_q;
        if (clr) begin
            shift_d = '0;
            idx_d   = '0;
        end else if (byte_valid) begin
            shift_d = {shift_q[15:0], byte_data};
            idx_d   = idx_q + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
            idx_q   <= '0;
        end else begin
            shift_q <= shift_d;
            idx_q   <= idx_d;
        end
    end

    // Only three bytes are stored; the fourth is used straight from the input.
    assign word      = {shift_q, byte_data};
    assign word_done = byte_valid && !clr && (idx_q == 2'd3);

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module  : imem_loader
// Brief   : Byte-stream instruction memory loader; holds the core in reset
//           until a checksummed image has been written.
// Revision: 1.0 - initial release
// ============================================================================
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       word_cnt
);

    state_t              state_q, state_d;
    logic [15:0]         len_q, len_d;
    logic [7:0]          xor_q, xor_d;
    logic [15:0]         cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                cpu_rst_q, cpu_rst_d;

    logic                xfer;
    logic                asm_clr;
    logic                asm_valid;
    logic [31:0]         asm_word;
    logic                asm_done;
    logic [15:0]         len_full;

    assign busy     = (state_q == ST_LEN_HI) || (state_q == ST_LEN_LO) ||
                      (state_q == ST_DATA)   || (state_q == ST_CHK);
    assign in_ready = busy;
    assign done     = (state_q == ST_DONE);
    assign err      = (state_q == ST_ERR);
    assign xfer     = in_valid && in_ready;
    assign len_full = {len_q[15:8], in_data};
    assign asm_valid = xfer && (state_q == ST_DATA);

    imem_loader_word_assembler u_word_assembler (
        .clk        (clk),
        .rst        (rst),
        .clr        (asm_clr),
        .byte_valid (asm_valid),
        .byte_data  (in_data),
        .word       (asm_word),
        .word_done  (asm_done)
    );

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        xor_d   = xor_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        asm_clr = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d = ST_LEN_HI;
                    xor_d   = '0;
                    cnt_d   = '0;
                    asm_clr = 1'b1;
                end
            end
            ST_LEN_HI: begin
                if (xfer) begin
                    len_d[15:8] = in_data;
                    xor_d       = xor_q ^ in_data;
                    state_d     = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (xfer) begin
                    len_d = len_full;
                    xor_d = xor_q ^ in_data;
                    if (32'(len_full) > DEPTH) begin
                        state_d = ST_ERR;
                    end else if (len_full == 16'd0) begin
                        state_d = ST_CHK;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (xfer) begin
                    xor_d = xor_q ^ in_data;
                    if (asm_done) begin
                        we_d    = 1'b1;
                        wdata_d = asm_word;
                        addr_d  = cnt_q[ADDR_W-1:0];
                        cnt_d   = cnt_q + 16'd1;
                        if (cnt_d == len_q) begin
                            state_d = ST_CHK;
                        end
                    end
                end
            end
            ST_CHK: begin
                if (xfer) begin
                    state_d = (in_data == xor_q) ? ST_DONE : ST_ERR;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Registered so the core sees reset drop exactly as DONE is entered.
        cpu_rst_d = (state_d != ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            len_q     <= '0;
            xor_q     <= '0;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cpu_rst_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            xor_q     <= xor_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cpu_rst_q <= cpu_rst_d;
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign cpu_rst    = cpu_rst_q;
    assign word_cnt   = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_imem_loader
// Brief   : Directed self-checking bench for the instruction memory loader.
// Revision: 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    localparam int ADDR_W = 10;

    logic              clk;
    logic              rst;
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_rst;
    logic              busy;
    logic              done;
    logic              err;
    logic [15:0]       word_cnt;

    int n_vec = 0;
    int n_err = 0;

    logic [ADDR_W-1:0] wr_addr[$];
    logic [31:0]       wr_data[$];

    imem_loader #(.DEPTH(256), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rst    (cpu_rst),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .word_cnt   (word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we) begin
            wr_addr.push_back(imem_addr);
            wr_data.push_back(imem_wdata);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            check_eq("ready_timeout", 32'(in_ready), 32'd1);
        end else begin
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] fb[$], input bit throttle);
        foreach (fb[i]) begin
            if (throttle) repeat ($urandom_range(0, 3)) @(negedge clk);
            send_byte(fb[i]);
        end
    endtask

    task automatic check_writes(input string tag, input logic [31:0] exp[$]);
        check_eq({tag, "_nwr"}, 32'(wr_data.size()), 32'(exp.size()));
        foreach (exp[i]) begin
            check_eq({tag, "_addr"}, (i < wr_addr.size()) ? 32'(wr_addr[i]) : 32'hFFFF_FFFF, 32'(i));
            check_eq({tag, "_data"}, (i < wr_data.size()) ? wr_data[i] : 32'hXXXX_XXXX, exp[i]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  fr[$];
        logic [31:0] ew[$];

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (2) @(negedge clk);
        check_eq("rst_cpu_rst",  32'(cpu_rst),    32'd1);
        check_eq("rst_in_ready", 32'(in_ready),   32'd0);
        check_eq("rst_we",       32'(imem_we),    32'd0);
        check_eq("rst_addr",     32'(imem_addr),  32'd0);
        check_eq("rst_wdata",    imem_wdata,      32'd0);
        check_eq("rst_word_cnt", 32'(word_cnt),   32'd0);
        check_eq("rst_flags",    {29'd0, busy, done, err}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Bytes offered with no start must be ignored.
        in_valid = 1'b1; in_data = 8'h55;
        repeat (4) begin
            @(negedge clk);
            check_eq("idle_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        check_eq("idle_nwr",     32'(wr_data.size()), 32'd0);
        check_eq("idle_cpu_rst", 32'(cpu_rst), 32'd1);
        check_eq("idle_busy",    32'(busy), 32'd0);

        // Basic two-word load, checksum 0x20.
        clear_log();
        pulse_start();
        check_eq("basic_busy",  32'(busy), 32'd1);
        fr = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
        send_frame(fr, 1'b0);
        check_eq("basic_pre_cpu_rst", 32'(cpu_rst), 32'd1);
        check_eq("basic_pre_done",    32'(done), 32'd0);
        send_byte(8'h20);
        check_eq("basic_done",     32'(done), 32'd1);
        check_eq("basic_cpu_rst",  32'(cpu_rst), 32'd0);
        check_eq("basic_word_cnt", 32'(word_cnt), 32'd2);
        ew = '{32'hDEADBEEF, 32'h01234567};
        check_writes("basic", ew);

        // start in DONE puts the core back into reset on the next edge.
        clear_log();
        pulse_start();
        check_eq("restart_cpu_rst", 32'(cpu_rst), 32'd1);
        check_eq("restart_done",    32'(done), 32'd0);
        check_eq("restart_busy",    32'(busy), 32'd1);

        // Same frame with a corrupted checksum.
        send_frame(fr, 1'b0);
        send_byte(8'h21);
        check_eq("badchk_err",     32'(err), 32'd1);
        check_eq("badchk_cpu_rst", 32'(cpu_rst), 32'd1);
        check_eq("badchk_cnt",     32'(word_cnt), 32'd2);
        check_writes("badchk", ew);

        // Length 0x0101 exceeds DEPTH.
        clear_log();
        pulse_start();
        fr = '{8'h01, 8'h01};
        send_frame(fr, 1'b0);
        repeat (3) @(negedge clk);
        check_eq("oversize_err",      32'(err), 32'd1);
        check_eq("oversize_in_ready", 32'(in_ready), 32'd0);
        check_eq("oversize_nwr",      32'(wr_data.size()), 32'd0);

        // Empty image.
        clear_log();
        pulse_start();
        fr = '{8'h00, 8'h00, 8'h00};
        send_frame(fr, 1'b0);
        check_eq("empty_done",    32'(done), 32'd1);
        check_eq("empty_cpu_rst", 32'(cpu_rst), 32'd0);
        check_eq("empty_cnt",     32'(word_cnt), 32'd0);
        check_eq("empty_nwr",     32'(wr_data.size()), 32'd0);

        // Four words with random in_valid gaps, checksum 0x04.
        clear_log();
        pulse_start();
        fr = '{8'h00, 8'h04,
               8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
               8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h00,
               8'h04};
        send_frame(fr, 1'b1);
        check_eq("throttle_done", 32'(done), 32'd1);
        check_eq("throttle_cnt",  32'(word_cnt), 32'd4);
        ew = '{32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00};
        check_writes("throttle", ew);

        // Reset after six data bytes of a three-word frame.
        clear_log();
        pulse_start();
        fr = '{8'h00, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h12, 8'h34};
        send_frame(fr, 1'b0);
        #2 rst = 1'b1;
        #1;
        check_eq("midrst_in_ready", 32'(in_ready), 32'd0);
        check_eq("midrst_cpu_rst",  32'(cpu_rst), 32'd1);
        check_eq("midrst_busy",     32'(busy), 32'd0);
        check_eq("midrst_cnt",      32'(word_cnt), 32'd0);
        ew = '{32'hAABBCCDD};
        check_writes("midrst", ew);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Full reload; a start pulse while busy must be ignored.
        clear_log();
        pulse_start();
        send_byte(8'h00);
        pulse_start();
        fr = '{8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67, 8'h20};
        send_frame(fr, 1'b0);
        check_eq("reload_done",    32'(done), 32'd1);
        check_eq("reload_cpu_rst", 32'(cpu_rst), 32'd0);
        check_eq("reload_cnt",     32'(word_cnt), 32'd2);
        ew = '{32'hDEADBEEF, 32'h01234567};
        check_writes("reload", ew);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
